// File: rtl/memory_write_arbiter.sv
// memory_write_arbiter
//   Shares the single write path of the memory write splitter between two
//   requesters: A (execute-stage data write) and B (microcode stack pushes for
//   interrupt, exception and task-switch sequences). The winning request is
//   registered and held stable for the whole split transaction. Completion and
//   faults are routed back to the owner only. Ownership is kept across locked
//   read-modify-write sequences, and an aborted transaction is drained on
//   wr_reset.
//
//   Configuration macro: WRITE_ARB_ROUND_ROBIN_EN
//     defined   - on simultaneous requests the requester other than `last` wins
//     undefined - fixed priority, A beats B
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_reset            pipeline flush, aborts the current write
//   reqX_do             write request (level, held until done or fault)
//   reqX_cpl/address/length/lock/rmw/data   request fields
//   reqX_done           completion pulse to the owner
//   reqX_page_fault, reqX_ac_fault          fault levels to the owner
//   write_*             request port towards the splitter (latched fields)
//   write_done          splitter completion pulse
//   write_page_fault, write_ac_fault        splitter faults, sticky until wr_reset
//   write_idle          splitter is in its IDLE state

module memory_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_reset,

  input  logic        reqa_do,
  input  logic [1:0]  reqa_cpl,
  input  logic [31:0] reqa_address,
  input  logic [2:0]  reqa_length,
  input  logic        reqa_lock,
  input  logic        reqa_rmw,
  input  logic [31:0] reqa_data,
  output logic        reqa_done,
  output logic        reqa_page_fault,
  output logic        reqa_ac_fault,

  input  logic        reqb_do,
  input  logic [1:0]  reqb_cpl,
  input  logic [31:0] reqb_address,
  input  logic [2:0]  reqb_length,
  input  logic        reqb_lock,
  input  logic        reqb_rmw,
  input  logic [31:0] reqb_data,
  output logic        reqb_done,
  output logic        reqb_page_fault,
  output logic        reqb_ac_fault,

  output logic        write_do,
  output logic [1:0]  write_cpl,
  output logic [31:0] write_address,
  output logic [2:0]  write_length,
  output logic        write_lock,
  output logic        write_rmw,
  output logic [31:0] write_data,
  input  logic        write_done,
  input  logic        write_page_fault,
  input  logic        write_ac_fault,
  input  logic        write_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_LOCKED,
    S_FAULT,
    S_DRAIN
  } state_t;

  state_t state;
  logic   owner;   // 0 = A, 1 = B
  logic   last;    // most recent grant

  logic        grant_valid;
  logic        grant_sel;
  logic        src;
  logic [1:0]  src_cpl;
  logic [31:0] src_address;
  logic [2:0]  src_length;
  logic        src_lock;
  logic        src_rmw;
  logic [31:0] src_data;
  logic        owner_do;

  // Arbitration between the two level requests.
  always_comb begin
    grant_valid = reqa_do | reqb_do;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
    if (reqa_do && reqb_do)
      grant_sel = ~last;
    else
      grant_sel = ~reqa_do;
`else
    // Fixed priority. With no request the select is a don't-care and simply
    // parks on the previous grant.
    if (reqa_do)
      grant_sel = 1'b0;
    else if (reqb_do)
      grant_sel = 1'b1;
    else
      grant_sel = last;
`endif
  end

  // In LOCKED only the current owner may re-issue, so fields come from it.
  always_comb begin
    src      = (state == S_LOCKED) ? owner : grant_sel;
    owner_do = owner ? reqb_do : reqa_do;
    if (src) begin
      src_cpl     = reqb_cpl;
      src_address = reqb_address;
      src_length  = reqb_length;
      src_lock    = reqb_lock;
      src_rmw     = reqb_rmw;
      src_data    = reqb_data;
    end else begin
      src_cpl     = reqa_cpl;
      src_address = reqa_address;
      src_length  = reqa_length;
      src_lock    = reqa_lock;
      src_rmw     = reqa_rmw;
      src_data    = reqa_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      last          <= 1'b1;
      write_cpl     <= '0;
      write_address <= '0;
      write_length  <= '0;
      write_lock    <= 1'b0;
      write_rmw     <= 1'b0;
      write_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!wr_reset && grant_valid) begin
            write_cpl     <= src_cpl;
            write_address <= src_address;
            write_length  <= src_length;
            write_lock    <= src_lock;
            write_rmw     <= src_rmw;
            write_data    <= src_data;
            owner         <= grant_sel;
            last          <= grant_sel;
            state         <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Fault wins over a done arriving in the same cycle.
          if (write_page_fault || write_ac_fault)
            state <= S_FAULT;
          else if (wr_reset)
            state <= S_DRAIN;
          else if (write_done)
            state <= write_lock ? S_LOCKED : S_IDLE;
        end
        S_LOCKED: begin
          if (wr_reset) begin
            state <= S_IDLE;
          end else if (owner_do) begin
            write_cpl     <= src_cpl;
            write_address <= src_address;
            write_length  <= src_length;
            write_lock    <= src_lock;
            write_rmw     <= src_rmw;
            write_data    <= src_data;
            state         <= S_BUSY;
          end
        end
        S_FAULT: begin
          if (wr_reset)
            state <= S_IDLE;
        end
        S_DRAIN: begin
          if (write_idle)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic busy;
  logic fault_vis;

  always_comb begin
    busy      = (state == S_BUSY);
    fault_vis = (state == S_BUSY) || (state == S_FAULT);

    write_do  = busy & ~wr_reset;

    reqa_done       = write_done & busy & ~owner;
    reqb_done       = write_done & busy & owner;
    reqa_page_fault = write_page_fault & fault_vis & ~owner;
    reqb_page_fault = write_page_fault & fault_vis & owner;
    reqa_ac_fault   = write_ac_fault & fault_vis & ~owner;
    reqb_ac_fault   = write_ac_fault & fault_vis & owner;
  end

endmodule

// File: tb/tb_memory_write_arbiter.sv
module tb_memory_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_reset;
  logic        reqa_do, reqb_do;
  logic [1:0]  reqa_cpl, reqb_cpl;
  logic [31:0] reqa_address, reqb_address;
  logic [2:0]  reqa_length, reqb_length;
  logic        reqa_lock, reqb_lock;
  logic        reqa_rmw, reqb_rmw;
  logic [31:0] reqa_data, reqb_data;
  logic        reqa_done, reqb_done;
  logic        reqa_page_fault, reqb_page_fault;
  logic        reqa_ac_fault, reqb_ac_fault;
  logic        write_do;
  logic [1:0]  write_cpl;
  logic [31:0] write_address;
  logic [2:0]  write_length;
  logic        write_lock, write_rmw;
  logic [31:0] write_data;
  logic        write_done, write_page_fault, write_ac_fault, write_idle;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  memory_write_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .wr_reset         (wr_reset),
    .reqa_do          (reqa_do),
    .reqa_cpl         (reqa_cpl),
    .reqa_address     (reqa_address),
    .reqa_length      (reqa_length),
    .reqa_lock        (reqa_lock),
    .reqa_rmw         (reqa_rmw),
    .reqa_data        (reqa_data),
    .reqa_done        (reqa_done),
    .reqa_page_fault  (reqa_page_fault),
    .reqa_ac_fault    (reqa_ac_fault),
    .reqb_do          (reqb_do),
    .reqb_cpl         (reqb_cpl),
    .reqb_address     (reqb_address),
    .reqb_length      (reqb_length),
    .reqb_lock        (reqb_lock),
    .reqb_rmw         (reqb_rmw),
    .reqb_data        (reqb_data),
    .reqb_done        (reqb_done),
    .reqb_page_fault  (reqb_page_fault),
    .reqb_ac_fault    (reqb_ac_fault),
    .write_do         (write_do),
    .write_cpl        (write_cpl),
    .write_address    (write_address),
    .write_length     (write_length),
    .write_lock       (write_lock),
    .write_rmw        (write_rmw),
    .write_data       (write_data),
    .write_done       (write_done),
    .write_page_fault (write_page_fault),
    .write_ac_fault   (write_ac_fault),
    .write_idle       (write_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wr_reset = 1'b0;
    reqa_do = 1'b0; reqb_do = 1'b0;
    reqa_cpl = '0; reqb_cpl = '0;
    reqa_address = '0; reqb_address = '0;
    reqa_length = '0; reqb_length = '0;
    reqa_lock = 1'b0; reqb_lock = 1'b0;
    reqa_rmw = 1'b0; reqb_rmw = 1'b0;
    reqa_data = '0; reqb_data = '0;
    write_done = 1'b0; write_page_fault = 1'b0; write_ac_fault = 1'b0;
    write_idle = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic exp_b;

  initial begin
    // ---------------- reset state ----------------
    apply_reset();
    check("rst_write_do", write_do, 0);
    check("rst_address", write_address, 0);
    check("rst_data", write_data, 0);
    check("rst_length", write_length, 0);
    check("rst_done_a", reqa_done, 0);
    check("rst_pf_b", reqb_page_fault, 0);

    // ---------------- single request from A ----------------
    reqa_do = 1'b1; reqa_address = 32'h0000_1000; reqa_length = 3'd4;
    reqa_data = 32'hDEAD_BEEF; reqa_cpl = 2'd3;
    #1;
    check("single_no_early_do", write_do, 0);
    tick();
    check("single_write_do", write_do, 1);
    check("single_address", write_address, 32'h0000_1000);
    check("single_length", write_length, 4);
    check("single_data", write_data, 32'hDEAD_BEEF);
    check("single_cpl", write_cpl, 3);
    write_done = 1'b1;
    #1;
    check("single_done_a", reqa_done, 1);
    check("single_done_b", reqb_done, 0);
    tick();
    write_done = 1'b0; reqa_do = 1'b0;
    #1;
    check("single_idle_do", write_do, 0);
    check("single_idle_done", reqa_done, 0);

    // ---------------- simultaneous requests x4 ----------------
    apply_reset();
    reqa_address = 32'h0000_00A0; reqb_address = 32'h0000_00B0;
    reqa_data = 32'h1111_1111; reqb_data = 32'h2222_2222;
    for (int r = 0; r < 4; r++) begin
`ifdef WRITE_ARB_ROUND_ROBIN_EN
      exp_b = (r % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      reqa_do = 1'b1; reqb_do = 1'b1;
      tick();
      check($sformatf("sim%0d_do", r), write_do, 1);
      check($sformatf("sim%0d_addr", r), write_address,
            exp_b ? 32'h0000_00B0 : 32'h0000_00A0);
      write_done = 1'b1;
      #1;
      check($sformatf("sim%0d_done_a", r), reqa_done, {31'd0, ~exp_b});
      check($sformatf("sim%0d_done_b", r), reqb_done, {31'd0, exp_b});
      tick();
      write_done = 1'b0; reqa_do = 1'b0; reqb_do = 1'b0;
      tick();
    end

    // ---------------- locked RMW ----------------
    apply_reset();
    reqa_do = 1'b1; reqa_lock = 1'b1; reqa_rmw = 1'b1; reqa_address = 32'h0000_2000;
    reqb_do = 1'b1; reqb_address = 32'h0000_00B0; reqb_data = 32'hCAFE_0001;
    tick();
    check("lock_addr1", write_address, 32'h0000_2000);
    check("lock_flag1", write_lock, 1);
    check("lock_rmw1", write_rmw, 1);
    write_done = 1'b1;
    tick();
    write_done = 1'b0; reqa_do = 1'b0;
    #1;
    check("locked_no_grant0", write_do, 0);
    tick();
    check("locked_no_grant1", write_do, 0);
    check("locked_addr_held", write_address, 32'h0000_2000);
    reqa_do = 1'b1; reqa_lock = 1'b0; reqa_address = 32'h0000_2004;
    tick();
    check("lock_reissue_do", write_do, 1);
    check("lock_addr2", write_address, 32'h0000_2004);
    check("lock_flag2", write_lock, 0);
    write_done = 1'b1;
    #1;
    check("lock_done_a", reqa_done, 1);
    check("lock_done_b", reqb_done, 0);
    tick();
    write_done = 1'b0; reqa_do = 1'b0; reqa_rmw = 1'b0;
    #1;
    check("lock_idle_do", write_do, 0);
    tick();
    check("b_granted_do", write_do, 1);
    check("b_granted_addr", write_address, 32'h0000_00B0);
    check("b_granted_data", write_data, 32'hCAFE_0001);

    // ---------------- fault while B owns (same-cycle done) ----------------
    write_page_fault = 1'b1; write_done = 1'b1;
    #1;
    check("fault_pf_b", reqb_page_fault, 1);
    check("fault_pf_a", reqa_page_fault, 0);
    check("fault_ac_b", reqb_ac_fault, 0);
    tick();
    write_done = 1'b0;
    #1;
    check("fault_state_do", write_do, 0);
    check("fault_held_b", reqb_page_fault, 1);
    check("fault_held_a", reqa_page_fault, 0);
    tick();
    check("fault_held2_b", reqb_page_fault, 1);
    wr_reset = 1'b1; reqb_do = 1'b0;
    tick();
    wr_reset = 1'b0; write_page_fault = 1'b0;
    #1;
    check("fault_cleared_b", reqb_page_fault, 0);
    check("fault_idle_do", write_do, 0);

    // ---------------- abort / drain ----------------
    reqa_do = 1'b1; reqa_address = 32'h0000_3000; reqa_data = 32'h1234_5678;
    write_idle = 1'b0;
    tick();
    check("abort_grant_do", write_do, 1);
    wr_reset = 1'b1;
    #1;
    check("abort_do_masked", write_do, 0);
    check("abort_no_done", reqa_done, 0);
    tick();
    wr_reset = 1'b0; reqa_do = 1'b0;
    reqb_do = 1'b1; reqb_address = 32'h0000_00B1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("drain%0d_do", c), write_do, 0);
      check($sformatf("drain%0d_addr", c), write_address, 32'h0000_3000);
      check($sformatf("drain%0d_data", c), write_data, 32'h1234_5678);
      if (c < 2) tick();
    end
    write_idle = 1'b1;
    tick();
    check("drain_idle_do", write_do, 0);
    check("drain_idle_addr", write_address, 32'h0000_3000);
    tick();
    check("drain_newgrant_do", write_do, 1);
    check("drain_newgrant_addr", write_address, 32'h0000_00B1);
    write_done = 1'b1;
    #1;
    check("drain_b_done", reqb_done, 1);
    check("drain_a_done", reqa_done, 0);
    tick();
    write_done = 1'b0; reqb_do = 1'b0;
    tick();

    // ---------------- asynchronous reset in BUSY ----------------
    reqa_do = 1'b1; reqa_address = 32'h0000_4000; reqa_data = 32'h5555_AAAA;
    tick();
    check("arst_pre_do", write_do, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_do", write_do, 0);
    check("arst_addr", write_address, 0);
    check("arst_data", write_data, 0);
    reqa_do = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_after_do", write_do, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/memory_write_arbiter.md
# memory_write_arbiter

- Shares the single write path of the memory write splitter (`write_do`/`write_done` request port) between two requesters.
  - Requester A: the execute-stage data write.
  - Requester B: microcode stack pushes for interrupt, exception and task-switch sequences.
- Registers the winning request, holds its fields stable for the whole split transaction and routes completion and faults back to the owner only.
- Keeps ownership across locked read-modify-write sequences.
- Drains an aborted transaction safely on `wr_reset`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_reset`  in  1  pipeline flush; aborts the current write
- `reqa_do`, `reqb_do`  in  1  write request, level; held until done or fault
- `reqa_cpl`, `reqb_cpl`  in  2  privilege level
- `reqa_address`, `reqb_address`  in  32  linear address
- `reqa_length`, `reqb_length`  in  3  bytes, 1..4
- `reqa_lock`, `reqb_lock`  in  1  locked write
- `reqa_rmw`, `reqb_rmw`  in  1  read-modify-write
- `reqa_data`, `reqb_data`  in  32  write data
- `reqa_done`, `reqb_done`  out  1  completion pulse
- `reqa_page_fault`, `reqb_page_fault`  out  1  page fault, level
- `reqa_ac_fault`, `reqb_ac_fault`  out  1  alignment-check fault, level
- `write_do`  out  1  request to splitter
- `write_cpl`  out  2
- `write_address`  out  32
- `write_length`  out  3
- `write_lock`  out  1
- `write_rmw`  out  1
- `write_data`  out  32
- `write_done`  in  1  splitter completion pulse
- `write_page_fault`, `write_ac_fault`  in  1  splitter faults; sticky until `wr_reset`
- `write_idle`  in  1  splitter state is IDLE

## Operation
- States:
  - IDLE: no owner.
  - BUSY: `write_do`=1.
  - LOCKED: owner held, no transaction in flight.
  - FAULT: fault held for the owner.
  - DRAIN: abort in progress.
- Register `owner` (0=A, 1=B). Register `last` holds the most recent grant; reset value 1.
- IDLE:
  - If `wr_reset`, no grant.
  - Otherwise arbitrate among asserted `reqX_do`.
  - On a grant: latch that requester's cpl/address/length/lock/rmw/data, set `owner` and `last`, go to BUSY.
- BUSY:
  - `write_page_fault|write_ac_fault` → FAULT. The fault has priority over a same-cycle done.
  - Else `wr_reset` → DRAIN.
  - Else `write_done` with latched lock=1 → LOCKED.
  - Else `write_done` → IDLE.
- LOCKED:
  - `wr_reset` → IDLE and release the lock.
  - Else the owner's `do` → latch its fields, go to BUSY.
  - The other requester is ignored.
- FAULT: `wr_reset` → IDLE.
- DRAIN: `write_idle` → IDLE. The latched fields stay unchanged while in DRAIN.
- Routing to requesters:
  - `reqX_done` = `write_done & state==BUSY & owner==X`.
  - `reqX_*_fault` = `write_*_fault & owner==X & state∈{BUSY,FAULT}`.
  - The non-owner always sees 0 on done and fault outputs.
- Downstream outputs:
  - `write_do` = `state==BUSY & ~wr_reset`.
  - `write_cpl`, `write_address`, `write_length`, `write_lock`, `write_rmw`, `write_data` come from the latched registers.
- Reset values:
  - State IDLE, `owner`=0, `last`=1.
  - `write_do` and all latched fields 0.
  - All requester done and fault outputs 0.

## Timing
- Grant latency: `reqX_do` sampled in cycle t gives `write_do`=1 in cycle t+1.
- `reqX_done` is combinational from `write_done`, in the same cycle.
- Requester handshake:
  - The requester deasserts `do` in the cycle after `done`.
  - The arbiter returns to IDLE in that same cycle and may grant a new request there.
- Back-to-back writes from one requester: minimum 1 idle cycle between `write_do` pulses; LOCKED allows re-issue with the same 1-cycle latency.
- `wr_reset` in DRAIN has no further effect. If `wr_reset` and `write_idle` are both 1 in DRAIN, the arbiter goes to IDLE but does not grant in that cycle.
- Asynchronous `rst` mid-transaction returns all outputs to reset values immediately. The splitter is reset by the same event.

## Configuration
- `WRITE_ARB_ROUND_ROBIN_EN` defined: when A and B request together, the requester ≠ `last` wins.
- Undefined: fixed priority, A always beats B. `last` is still maintained but unused for arbitration.

## Test plan
- Single request: `reqa_do`=1, address 0x1000, length 4, data 0xDEADBEEF.
  - `write_do` rises next cycle with those fields.
  - `write_done` pulse gives `reqa_done`=1, `reqb_done`=0, then IDLE.
- Simultaneous requests, repeated 4×, with `last`=1 after reset:
  - With the macro: grants alternate A,B,A,B.
  - Without the macro: A,A,A,A.
- Locked RMW: A writes with lock=1 and completes; B is asserted meanwhile.
  - B is not granted while in LOCKED.
  - A's next write with lock=0 completes, then B is granted.
- Fault: B owns the path, `write_page_fault`=1.
  - `reqb_page_fault`=1 and `reqa_page_fault`=0, held in FAULT.
  - `wr_reset` returns to IDLE.
- Abort: `wr_reset` pulses 1 cycle after A's grant, and `write_idle` stays 0 for 3 cycles.
  - `write_do`=0, fields are held, no `reqa_done`.
  - IDLE in the cycle `write_idle`=1; a new request is granted the cycle after.
- Async `rst` asserted while in BUSY: `write_do` drops to 0 immediately, in the same cycle.
